jpeg_dequantizer: RTL and testbench

Parametrised 8x8 dequantizer for the JPEG decode path. It sits between entropy decode/zig-zag reorder and the column IDCT. Each accepted column of eight signed coefficients is multiplied lane-wise by per-position entries from one of NUM_TABLES runtime-loadable quantization tables. The block has a valid/ready handshake with full backpressure, block framing, and a selectable overflow policy.

---
 rtl/jpeg_dequantizer.sv | 163 ++++++++++++++++
 tb/tb_jpeg_dequantizer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_dequantizer.sv
// 8x8 JPEG dequantizer: two-stage lane-wise coefficient x Q-table multiply.
// Define DEQUANT_SATURATE_EN to clamp lanes; otherwise the low OUT_W bits are kept.
module jpeg_dequantizer #(
   parameter int COEF_W     = 12,
   parameter int Q_W        = 8,
   parameter int OUT_W      = 12,
   parameter int NUM_TABLES = 2,
   parameter int TSEL_W     = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  tbl_wr_en,
   input  logic [TSEL_W-1:0]     tbl_wr_sel,
   input  logic [5:0]            tbl_wr_addr,
   input  logic [Q_W-1:0]        tbl_wr_data,
   input  logic [8*COEF_W-1:0]   column_in,
   input  logic                  first_in,
   input  logic [TSEL_W-1:0]     tbl_sel_in,
   input  logic                  valid_in,
   output logic                  ready_out,
   output logic [8*OUT_W-1:0]    column_out,
   output logic [2:0]            col_idx_out,
   output logic                  last_out,
   output logic                  valid_out,
   input  logic                  ready_in,
   output logic                  sync_err_out
);

   localparam int P_W = COEF_W + Q_W + 1;

   logic [Q_W-1:0]          tbl [NUM_TABLES][64];
   logic [2:0]              cnt;
   logic [TSEL_W-1:0]       act_tbl;

   logic                    s1_valid;
   logic [8*COEF_W-1:0]     s1_coef;
   logic [2:0]              s1_col;
   logic                    s1_last;
   logic [8*Q_W-1:0]        s1_q;

   logic                    accept;
   logic                    advance;
   logic                    wr_ok;
   logic [TSEL_W-1:0]       sel_safe;
   logic [TSEL_W-1:0]       lk_tbl;
   logic [2:0]              lk_col;
   logic [8*Q_W-1:0]        lk_q;
   logic [8*OUT_W-1:0]      res;
   logic signed [P_W-1:0]   c_ext;
   logic signed [P_W-1:0]   q_ext;
`ifdef DEQUANT_SATURATE_EN
   localparam logic signed [P_W-1:0] SAT_HI = P_W'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [P_W-1:0] SAT_LO = ~SAT_HI;
   logic signed [P_W-1:0]   prod;
`endif

   assign advance   = !valid_out || ready_in;
   assign ready_out = !s1_valid || advance;
   assign accept    = valid_in && ready_out;
   assign wr_ok     = int'(tbl_wr_sel) < NUM_TABLES;
   assign sel_safe  = (int'(tbl_sel_in) < NUM_TABLES) ? tbl_sel_in : '0;

   // A block's first column already uses the table it selects.
   assign lk_tbl = first_in ? sel_safe : act_tbl;
   assign lk_col = first_in ? 3'd0 : cnt;

   always_comb begin
      lk_q = '0;
      for (int i = 0; i < 8; i++) begin
         lk_q[i*Q_W +: Q_W] = tbl[lk_tbl][{lk_col, 3'(i)}];
      end
   end

   always_comb begin
      res   = '0;
      c_ext = '0;
      q_ext = '0;
`ifdef DEQUANT_SATURATE_EN
      prod  = '0;
`endif
      for (int i = 0; i < 8; i++) begin
         c_ext = {{(Q_W+1){s1_coef[i*COEF_W+COEF_W-1]}},
                  s1_coef[i*COEF_W +: COEF_W]};
         q_ext = {{(COEF_W+1){1'b0}}, s1_q[i*Q_W +: Q_W]};
`ifdef DEQUANT_SATURATE_EN
         prod = c_ext * q_ext;
         if (prod > SAT_HI)
            res[i*OUT_W +: OUT_W] = SAT_HI[OUT_W-1:0];
         else if (prod < SAT_LO)
            res[i*OUT_W +: OUT_W] = SAT_LO[OUT_W-1:0];
         else
            res[i*OUT_W +: OUT_W] = prod[OUT_W-1:0];
`else
         res[i*OUT_W +: OUT_W] = OUT_W'(c_ext * q_ext);
`endif
      end
   end

   // Lookup reads the registered table, so a same-cycle write is seen next cycle.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int t = 0; t < NUM_TABLES; t++)
            for (int a = 0; a < 64; a++)
               tbl[t][a] <= Q_W'(1);
      end else if (tbl_wr_en && wr_ok) begin
         tbl[tbl_wr_sel][tbl_wr_addr] <= tbl_wr_data;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cnt          <= '0;
         act_tbl      <= '0;
         sync_err_out <= 1'b0;
      end else begin
         sync_err_out <= 1'b0;
         if (accept) begin
            if (first_in) begin
               cnt          <= 3'd1;
               act_tbl      <= sel_safe;
               sync_err_out <= (cnt != 3'd0);
            end else begin
               cnt <= cnt + 3'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         s1_valid <= 1'b0;
         s1_coef  <= '0;
         s1_col   <= '0;
         s1_last  <= 1'b0;
         s1_q     <= '0;
      end else if (ready_out) begin
         s1_valid <= valid_in;
         if (accept) begin
            s1_coef <= column_in;
            s1_col  <= lk_col;
            s1_last <= (lk_col == 3'd7);
            s1_q    <= lk_q;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         valid_out   <= 1'b0;
         column_out  <= '0;
         col_idx_out <= '0;
         last_out    <= 1'b0;
      end else if (advance) begin
         valid_out <= s1_valid;
         if (s1_valid) begin
            column_out  <= res;
            col_idx_out <= s1_col;
            last_out    <= s1_last;
         end
      end
   end

endmodule

// File: tb/tb_jpeg_dequantizer.sv
// Directed bench for jpeg_dequantizer: framing, tables, stalls, arithmetic.
module tb_jpeg_dequantizer;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          tbl_wr_en;
   logic [0:0]    tbl_wr_sel;
   logic [5:0]    tbl_wr_addr;
   logic [7:0]    tbl_wr_data;
   logic [95:0]   column_in;
   logic          first_in;
   logic [0:0]    tbl_sel_in;
   logic          valid_in;
   logic          ready_out;
   logic [95:0]   column_out;
   logic [2:0]    col_idx_out;
   logic          last_out;
   logic          valid_out;
   logic          ready_in;
   logic          sync_err_out;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [95:0] col;
      logic [2:0]  idx;
      logic        last;
   } out_t;

   out_t        q[$];
   logic [95:0] e;

`ifdef DEQUANT_SATURATE_EN
   localparam int BIG = 2047;
`else
   localparam int BIG = 1793;
`endif

   jpeg_dequantizer dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .tbl_wr_en    (tbl_wr_en),
      .tbl_wr_sel   (tbl_wr_sel),
      .tbl_wr_addr  (tbl_wr_addr),
      .tbl_wr_data  (tbl_wr_data),
      .column_in    (column_in),
      .first_in     (first_in),
      .tbl_sel_in   (tbl_sel_in),
      .valid_in     (valid_in),
      .ready_out    (ready_out),
      .column_out   (column_out),
      .col_idx_out  (col_idx_out),
      .last_out     (last_out),
      .valid_out    (valid_out),
      .ready_in     (ready_in),
      .sync_err_out (sync_err_out)
   );

   always #5 clk_in = ~clk_in;

   always @(negedge clk_in)
      if (valid_out && ready_in)
         q.push_back('{column_out, col_idx_out, last_out});

   task automatic chk(input string tag, input logic [95:0] obs,
                      input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [95:0] fill(input int v);
      logic [95:0] r;
      for (int i = 0; i < 8; i++) r[i*12 +: 12] = 12'(v);
      return r;
   endfunction

   function automatic logic [95:0] colval(input int k);
      logic [95:0] r;
      for (int i = 0; i < 8; i++) r[i*12 +: 12] = 12'(k * 16 + i);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      rst_in    = 1'b1;
      valid_in  = 1'b0;
      first_in  = 1'b0;
      tbl_wr_en = 1'b0;
      ready_in  = 1'b1;
      tick();
      tick();
      rst_in = 1'b0;
      q.delete();
   endtask

   task automatic wr(input logic s, input int a, input int d);
      tbl_wr_en   = 1'b1;
      tbl_wr_sel  = s;
      tbl_wr_addr = 6'(a);
      tbl_wr_data = 8'(d);
      tick();
      tbl_wr_en = 1'b0;
   endtask

   task automatic send(input logic [95:0] c, input logic f, input logic s);
      int   n;
      logic acc;
      column_in  = c;
      first_in   = f;
      tbl_sel_in = s;
      valid_in   = 1'b1;
      n   = 0;
      acc = 1'b0;
      while (!acc && n < 100) begin
         @(negedge clk_in);
         acc = ready_out;
         tick();
         n++;
      end
      chk("send accepted", 96'(acc), 96'(1));
      valid_in = 1'b0;
      first_in = 1'b0;
   endtask

   task automatic drain(input int n);
      int k;
      k = 0;
      while (q.size() < n && k < 50) begin
         tick();
         k++;
      end
      chk("drain count", 96'(q.size()), 96'(n));
   endtask

   task automatic expect_col(input string tag, input logic [95:0] c,
                             input int idx);
      out_t o;
      chk({tag, " avail"}, 96'(q.size() != 0), 96'(1));
      if (q.size() == 0) return;
      o = q.pop_front();
      chk({tag, " data"}, o.col, c);
      chk({tag, " idx"}, 96'(o.idx), 96'(idx));
      chk({tag, " last"}, 96'(o.last), 96'(idx == 7));
   endtask

   initial begin
      column_in   = '0;
      tbl_sel_in  = '0;
      tbl_wr_sel  = '0;
      tbl_wr_addr = '0;
      tbl_wr_data = '0;
      do_reset();

      // reset state and first-column latency
      chk("rst valid_out", 96'(valid_out), 96'(0));
      chk("rst ready_out", 96'(ready_out), 96'(1));
      chk("rst column_out", column_out, 96'(0));
      chk("rst col_idx", 96'(col_idx_out), 96'(0));
      chk("rst last", 96'(last_out), 96'(0));
      chk("rst sync_err", 96'(sync_err_out), 96'(0));
      send(fill(-5), 1'b1, 1'b0);
      chk("lat1 valid_out", 96'(valid_out), 96'(0));
      tick();
      chk("lat2 valid_out", 96'(valid_out), 96'(1));
      chk("lat2 lanes", column_out, fill(-5));
      drain(1);
      expect_col("neg5", fill(-5), 0);

      // single table entry override
      do_reset();
      wr(1'b0, 9, 12);
      for (int i = 0; i < 8; i++) e[i*12 +: 12] = 12'(2 * i + 1);
      send(fill(3), 1'b1, 1'b0);
      send(e, 1'b0, 1'b0);
      for (int k = 2; k < 8; k++) send(fill(1), 1'b0, 1'b0);
      drain(8);
      expect_col("q9 c0", fill(3), 0);
      e[12 +: 12] = 12'd36;
      expect_col("q9 c1", e, 1);
      for (int k = 2; k < 8; k++) expect_col("q9 cn", fill(1), k);

      // table 1 block then table 0 block
      do_reset();
      for (int a = 0; a < 64; a++) wr(1'b1, a, 2);
      for (int k = 0; k < 8; k++) send(fill(7), k == 0, 1'b1);
      for (int k = 0; k < 8; k++) send(fill(7), k == 0, 1'b0);
      drain(16);
      for (int k = 0; k < 8; k++) expect_col("t1", fill(14), k);
      for (int k = 0; k < 8; k++) expect_col("t0", fill(7), k);

      // downstream stall mid-stream
      do_reset();
      for (int k = 0; k < 3; k++) send(colval(k), k == 0, 1'b0);
      ready_in = 1'b0;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk_in);
         chk("stall ready_out", 96'(ready_out), 96'(0));
         chk("stall hold data", column_out, colval(1));
         chk("stall hold idx", 96'(col_idx_out), 96'(1));
         tick();
      end
      ready_in = 1'b1;
      for (int k = 3; k < 8; k++) send(colval(k), 1'b0, 1'b0);
      drain(8);
      for (int s = 0; s < 4; s++) tick();
      chk("stall no dup", 96'(q.size()), 96'(8));
      for (int k = 0; k < 8; k++) expect_col("stall", colval(k), k);

      // overflow policy, zero entry, write/lookup same cycle
      do_reset();
      wr(1'b0, 0, 255);
      wr(1'b0, 1, 255);
      wr(1'b0, 2, 0);
      e = '0;
      e[0 +: 12]  = 12'd2047;
      e[12 +: 12] = 12'(-2048);
      e[24 +: 12] = 12'd100;
      e[36 +: 12] = 12'd5;
      tbl_wr_en   = 1'b1;
      tbl_wr_sel  = 1'b0;
      tbl_wr_addr = 6'd3;
      tbl_wr_data = 8'd9;
      send(e, 1'b1, 1'b0);
      tbl_wr_en = 1'b0;
      send(e, 1'b1, 1'b0);
      drain(2);
      e = '0;
      e[0 +: 12]  = 12'(BIG);
      e[12 +: 12] = 12'(-2048);
      e[36 +: 12] = 12'd5;
      expect_col("ovf old", e, 0);
      e[36 +: 12] = 12'd45;
      expect_col("ovf new", e, 0);

      // framing error on 4th column
      do_reset();
      for (int k = 0; k < 3; k++) send(fill(k + 1), k == 0, 1'b0);
      chk("sync quiet", 96'(sync_err_out), 96'(0));
      send(fill(4), 1'b1, 1'b0);
      chk("sync pulse", 96'(sync_err_out), 96'(1));
      send(fill(5), 1'b0, 1'b0);
      chk("sync one cycle", 96'(sync_err_out), 96'(0));
      drain(5);
      for (int k = 0; k < 3; k++) expect_col("sync pre", fill(k + 1), k);
      expect_col("sync restart", fill(4), 0);
      expect_col("sync next", fill(5), 1);

      // reset mid-block restores identity tables
      wr(1'b0, 0, 50);
      send(fill(2), 1'b1, 1'b0);
      send(fill(2), 1'b0, 1'b0);
      rst_in = 1'b1;
      tick();
      chk("midrst valid_out", 96'(valid_out), 96'(0));
      chk("midrst column_out", column_out, 96'(0));
      rst_in = 1'b0;
      q.delete();
      send(fill(2), 1'b1, 1'b0);
      drain(1);
      expect_col("midrst ident", fill(2), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
